// File: rtl/ibus_arbiter.sv
// Two-master IBUS arbiter: CPU (M0) and DMAC (M1) share on-chip slaves through a registered grant.
// A bounded DMA burst counter keeps a pending CPU from starving; CPU locked cycles pin the grant.
module ibus_arbiter #(
  parameter bit          DMA_PRIO  = 1'b1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_r,
  input  logic        ce_f,
  input  logic [27:0] cpu_a,
  input  logic [31:0] cpu_di,
  output logic [31:0] cpu_do,
  input  logic [3:0]  cpu_ba,
  input  logic        cpu_we,
  input  logic        cpu_req,
  input  logic        cpu_lock,
  output logic        cpu_busy,
  input  logic [27:0] dma_a,
  input  logic [31:0] dma_di,
  output logic [31:0] dma_do,
  input  logic [3:0]  dma_ba,
  input  logic        dma_we,
  input  logic        dma_req,
  output logic        dma_busy,
  output logic [27:0] ibus_a,
  output logic [31:0] ibus_do,
  input  logic [31:0] ibus_di,
  output logic [3:0]  ibus_ba,
  output logic        ibus_we,
  output logic        ibus_req,
  input  logic        ibus_busy,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DMA  = 2'b10
  } gnt_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  gnt_t       gnt_reg, gnt_next;
  logic [3:0] bcnt_reg, bcnt_next;
  logic       cpu_done, dma_done, rearb;

  // Falling-phase enable is part of the common bus interface but carries no state here.
  logic unused_ce_f;
  assign unused_ce_f = ce_f;

  always_comb begin
    cpu_done = (gnt_reg == GNT_CPU) && cpu_req && !ibus_busy;
    dma_done = (gnt_reg == GNT_DMA) && dma_req && !ibus_busy;
    rearb    = (gnt_reg == GNT_NONE) || cpu_done || dma_done ||
               ((gnt_reg == GNT_CPU) && !cpu_req) ||
               ((gnt_reg == GNT_DMA) && !dma_req);

    bcnt_next = bcnt_reg;
    if (!cpu_req || cpu_done)
      bcnt_next = 4'd0;
    else if (dma_done && (bcnt_reg != BURST_MAX))
      bcnt_next = bcnt_reg + 4'd1;

    // Selection looks at the post-update count so the burst ends right on its last completion.
    gnt_next = gnt_reg;
    if ((gnt_reg == GNT_CPU) && cpu_lock) begin
      gnt_next = GNT_CPU;
    end else if (rearb) begin
      case ({cpu_req, dma_req})
        2'b11: begin
          if (bcnt_next == BURST_MAX) gnt_next = GNT_CPU;
          else if (DMA_PRIO)          gnt_next = GNT_DMA;
          else                        gnt_next = GNT_CPU;
        end
        2'b10:   gnt_next = GNT_CPU;
        2'b01:   gnt_next = GNT_DMA;
        default: gnt_next = GNT_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_reg  <= GNT_NONE;
      bcnt_reg <= 4'd0;
    end else if (ce_r) begin
      gnt_reg  <= gnt_next;
      bcnt_reg <= bcnt_next;
    end
  end

  always_comb begin
    ibus_a   = '0;
    ibus_do  = '0;
    ibus_ba  = '0;
    ibus_we  = 1'b0;
    ibus_req = 1'b0;
    cpu_busy = cpu_req;
    dma_busy = dma_req;
    case (gnt_reg)
      GNT_CPU: begin
        ibus_a   = cpu_a;
        ibus_do  = cpu_di;
        ibus_ba  = cpu_ba;
        ibus_we  = cpu_we;
        ibus_req = cpu_req;
        cpu_busy = ibus_busy;
      end
      GNT_DMA: begin
        ibus_a   = dma_a;
        ibus_do  = dma_di;
        ibus_ba  = dma_ba;
        ibus_we  = dma_we;
        ibus_req = dma_req;
        dma_busy = ibus_busy;
      end
      default: ;
    endcase
  end

  assign cpu_do = ibus_di;
  assign dma_do = ibus_di;
  assign gnt    = gnt_reg;

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench for ibus_arbiter with default parameters (DMA_PRIO=1, MAX_BURST=4).
module tb_ibus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, ce_r, ce_f;
  logic [27:0] cpu_a, dma_a, ibus_a;
  logic [31:0] cpu_di, cpu_do, dma_di, dma_do, ibus_do, ibus_di;
  logic [3:0]  cpu_ba, dma_ba, ibus_ba;
  logic        cpu_we, cpu_req, cpu_lock, cpu_busy;
  logic        dma_we, dma_req, dma_busy;
  logic        ibus_we, ibus_req, ibus_busy;
  logic [1:0]  gnt;
  int          total = 0;
  int          bad   = 0;

  ibus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ce_r(ce_r), .ce_f(ce_f),
    .cpu_a(cpu_a), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ba(cpu_ba), .cpu_we(cpu_we),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_busy(cpu_busy),
    .dma_a(dma_a), .dma_di(dma_di), .dma_do(dma_do), .dma_ba(dma_ba), .dma_we(dma_we),
    .dma_req(dma_req), .dma_busy(dma_busy),
    .ibus_a(ibus_a), .ibus_do(ibus_do), .ibus_di(ibus_di), .ibus_ba(ibus_ba),
    .ibus_we(ibus_we), .ibus_req(ibus_req), .ibus_busy(ibus_busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %s observed=%h expected=%h ok", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] burst_exp [4];

  initial begin
    burst_exp[0] = 2'b10; burst_exp[1] = 2'b10; burst_exp[2] = 2'b10; burst_exp[3] = 2'b01;
    rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b0;
    cpu_a = '0; cpu_di = '0; cpu_ba = 4'hf; cpu_we = 1'b0; cpu_req = 1'b1; cpu_lock = 1'b0;
    dma_a = '0; dma_di = '0; dma_ba = '0; dma_we = 1'b0; dma_req = 1'b0;
    ibus_di = 32'hcafe0001; ibus_busy = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ibus_req", 32'(ibus_req), 32'h0);
    chk("rst_cpu_busy", 32'(cpu_busy), 32'h1);
    chk("rst_dma_busy", 32'(dma_busy), 32'h0);
    tick;
    chk("rst_hold_gnt", 32'(gnt), 32'h0);
    chk("rst_ibus_a", 32'(ibus_a), 32'h0);

    // 1: single CPU request from NONE, one cycle of arbitration latency
    rst_n = 1'b1; cpu_a = 28'h0000100;
    #1;
    chk("t1_busy_arb", 32'(cpu_busy), 32'h1);
    tick;
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_ibus_a", 32'(ibus_a), 32'h0000100);
    chk("t1_ibus_ba", 32'(ibus_ba), 32'hf);
    chk("t1_cpu_busy", 32'(cpu_busy), 32'h0);
    chk("t1_cpu_do", cpu_do, 32'hcafe0001);
    ce_r = 1'b0; cpu_req = 1'b0;
    #1;
    chk("t1_drop_req", 32'(ibus_req), 32'h0);
    tick;
    chk("t1_ce_gate", 32'(gnt), 32'h1);
    ce_r = 1'b1;
    tick;
    chk("t1_idle", 32'(gnt), 32'h0);

    // 2: simultaneous requests, DMA wins; CPU stalls until DMA releases
    cpu_req = 1'b1; dma_req = 1'b1;
    dma_a = 28'h0abcde0; dma_we = 1'b1; dma_di = 32'h12345678; dma_ba = 4'h3;
    tick;
    chk("t2_gnt", 32'(gnt), 32'h2);
    chk("t2_ibus_a", 32'(ibus_a), 32'h0abcde0);
    chk("t2_ibus_do", ibus_do, 32'h12345678);
    chk("t2_ibus_we", 32'(ibus_we), 32'h1);
    chk("t2_cpu_busy", 32'(cpu_busy), 32'h1);
    chk("t2_dma_busy", 32'(dma_busy), 32'h0);
    chk("t2_dma_do", dma_do, 32'hcafe0001);
    tick;
    chk("t2_regrant", 32'(gnt), 32'h2);
    dma_req = 1'b0;
    #1;
    chk("t2_cpu_busy_wait", 32'(cpu_busy), 32'h1);
    tick;
    chk("t2_cpu_gnt", 32'(gnt), 32'h1);
    chk("t2_cpu_a", 32'(ibus_a), 32'h0000100);
    chk("t2_cpu_busy_go", 32'(cpu_busy), 32'h0);
    tick;

    // 3: bounded DMA burst, twice, proving the count restarts after the CPU slot
    dma_req = 1'b1;
    tick;
    chk("t3_dma_start", 32'(gnt), 32'h2);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        tick;
        chk($sformatf("t3_burst%0d_%0d", r, k), 32'(gnt), 32'(burst_exp[k]));
      end
      if (r == 0) begin
        tick;
        chk("t3_dma_resume", 32'(gnt), 32'h2);
      end
    end

    // 4: locked CPU sequence keeps the grant despite DMA request
    cpu_lock = 1'b1;
    tick;
    chk("t4_lock1", 32'(gnt), 32'h1);
    chk("t4_dma_busy", 32'(dma_busy), 32'h1);
    tick;
    chk("t4_lock2", 32'(gnt), 32'h1);
    cpu_lock = 1'b0;
    tick;
    chk("t4_unlock", 32'(gnt), 32'h2);

    // 5: slave wait states hold the grant
    ibus_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("t5_gnt%0d", k), 32'(gnt), 32'h2);
      chk($sformatf("t5_busy%0d", k), 32'(dma_busy), 32'h1);
    end
    ibus_busy = 1'b0;
    #1;
    chk("t5_busy_clear", 32'(dma_busy), 32'h0);
    tick;
    chk("t5_after", 32'(gnt), 32'h2);

    // 6: asynchronous reset mid DMA transfer
    ibus_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_ibus_req", 32'(ibus_req), 32'h0);
    chk("t6_dma_busy", 32'(dma_busy), 32'h1);
    tick;
    rst_n = 1'b1; ibus_busy = 1'b0;
    tick;
    chk("t6_rearb", 32'(gnt), 32'h2);
    dma_req = 1'b0;
    tick;
    chk("t6_cpu", 32'(gnt), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
